// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable RAM with sweep clear.
//   ram_state_e    : clear-controller state (IDLE, CLEAR)
//   LANE_W_DEFAULT : default bits per write-enable lane
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_state_e;

    localparam int unsigned LANE_W_DEFAULT = 8;

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear-sweep controller for ram_be_clr.
// Walks the array once, one address per cycle from 0 to DEPTH-1, while busy is high.
// Reset lands in CLEAR at address 0, so the array is zeroed automatically after reset.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   clr   - request (re)start of the sweep at address 0
//   busy  - high in every CLEAR cycle; the array writes zero to addr this cycle
//   addr  - address being cleared this cycle
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] addr
);

    ram_state_e    state_q;
    logic [AW-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        addr_q  <= '0;
                    end
                end
                CLEAR: begin
                    if (clr) begin
                        // Restart: the current address is still zeroed this cycle.
                        addr_q <= '0;
                    end else if (addr_q == AW'(DEPTH - 1)) begin
                        // End of sweep; the counter wrap is never a second pass.
                        state_q <= IDLE;
                        addr_q  <= '0;
                    end else begin
                        addr_q <= addr_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    assign busy = (state_q == CLEAR);
    assign addr = addr_q;

endmodule

// File: rtl/ram_be_clr.sv
// Single-clock simple dual-port RAM with per-lane write enables and a sweep clear.
// Optional feature macro: RAM_BE_CLR_BYPASS_EN -- when defined, a read that hits the
// address written in the same cycle returns the newly written lanes (others from array);
// otherwise the read returns the old contents.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   clr / busy            - start clear sweep / sweep in progress (writes and reads ignored)
//   data, wraddress, wren - write port
//   be                    - per-lane write enable, lane i = data[i*LANE_W +: LANE_W]
//   rdaddress, rden       - read port
//   q, rvalid             - registered read data and its valid strobe
module ram_be_clr
    import ram_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned LANE_W = LANE_W_DEFAULT,
    localparam int unsigned NL    = WIDTH / LANE_W,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             busy,
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    wraddress,
    input  logic             wren,
    input  logic [NL-1:0]    be,
    input  logic [AW-1:0]    rdaddress,
    input  logic             rden,
    output logic [WIDTH-1:0] q,
    output logic             rvalid
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    clr_addr;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] q_q;
    logic             rvalid_q;

    ram_clr_ctrl #(
        .DEPTH (DEPTH)
    ) u_clr_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .busy  (busy),
        .addr  (clr_addr)
    );

    assign wr_en = wren && !busy;
    assign rd_en = rden && !busy;

    // Storage has no reset; its contents are defined only by the sweep.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (busy) begin
                mem[clr_addr] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NL; i++) begin
                    if (be[i]) begin
                        mem[wraddress][i*LANE_W +: LANE_W] <= data[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[rdaddress];
`ifdef RAM_BE_CLR_BYPASS_EN
        if (wr_en && (wraddress == rdaddress)) begin
            for (int i = 0; i < NL; i++) begin
                if (be[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q      <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
                q_q <= rd_word;
            end
        end
    end

    assign q      = q_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_be_clr.sv
// Self-checking bench for ram_be_clr (WIDTH=32, DEPTH=64, LANE_W=8).
module tb_ram_be_clr;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        busy;
    logic [31:0] data;
    logic [5:0]  wraddress;
    logic        wren;
    logic [3:0]  be;
    logic [5:0]  rdaddress;
    logic        rden;
    logic [31:0] q;
    logic        rvalid;

    int checks = 0;
    int errors = 0;

    ram_be_clr #(
        .WIDTH  (32),
        .DEPTH  (64),
        .LANE_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .busy      (busy),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .be        (be),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q),
        .rvalid    (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wren;
        logic [3:0]  be;
        logic [5:0]  wa;
        logic [31:0] data;
        logic        rden;
        logic [5:0]  ra;
        logic [31:0] exp_q;
        logic        exp_rv;
    } vec_t;

    vec_t vecs[16];

`ifdef RAM_BE_CLR_BYPASS_EN
    localparam logic [31:0] ExpColFull = 32'hDEADBEEF;
    localparam logic [31:0] ExpColPart = 32'h120000AB;
`else
    localparam logic [31:0] ExpColFull = 32'h00000000;
    localparam logic [31:0] ExpColPart = 32'h12000000;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clr = 0; wren = 0; be = 0; data = 0; wraddress = 0; rden = 0; rdaddress = 0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
        wren = 1; wraddress = a; data = d; be = b;
        tick();
        idle_inputs();
    endtask

    task automatic do_read(input logic [5:0] a, input logic [31:0] exp, input string name);
        rden = 1; rdaddress = a;
        tick();
        idle_inputs();
        check({name, "_q"}, q, exp);
        check({name, "_rv"}, {31'b0, rvalid}, 32'd1);
    endtask

    initial begin
        int n;
        vecs[0]  = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd0,  32'h00000000, 1};
        vecs[1]  = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd31, 32'h00000000, 1};
        vecs[2]  = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd63, 32'h00000000, 1};
        vecs[3]  = '{1, 4'hF, 6'd5,  32'hAABBCCDD, 0, 6'd0,  32'h00000000, 0};
        vecs[4]  = '{1, 4'h5, 6'd5,  32'h11223344, 0, 6'd0,  32'h00000000, 0};
        vecs[5]  = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd5,  32'hAA22CC44, 1};
        vecs[6]  = '{1, 4'h0, 6'd7,  32'hFFFFFFFF, 0, 6'd0,  32'hAA22CC44, 0};
        vecs[7]  = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd7,  32'h00000000, 1};
        vecs[8]  = '{1, 4'h8, 6'd10, 32'h12345678, 0, 6'd0,  32'h00000000, 0};
        vecs[9]  = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd10, 32'h12000000, 1};
        vecs[10] = '{1, 4'hF, 6'd63, 32'hCAFEF00D, 0, 6'd0,  32'h12000000, 0};
        vecs[11] = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd63, 32'hCAFEF00D, 1};
        vecs[12] = '{1, 4'hF, 6'd9,  32'hDEADBEEF, 1, 6'd9,  ExpColFull,   1};
        vecs[13] = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd9,  32'hDEADBEEF, 1};
        vecs[14] = '{1, 4'h1, 6'd10, 32'h000000AB, 1, 6'd10, ExpColPart,   1};
        vecs[15] = '{0, 4'h0, 6'd0,  32'h0,        1, 6'd10, 32'h120000AB, 1};

        // Reset: two cycles low, then auto-clear for DEPTH cycles.
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        check("reset_q", q, 32'h0);
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd1);
        rst_n = 1;
        n = 0;
        while (busy && n < 500) begin
            n++;
            tick();
        end
        check("reset_busy_cycles", n, 64);

        // Table-driven single-cycle vectors; outputs reflect the vector just applied.
        foreach (vecs[i]) begin
            wren = vecs[i].wren; be = vecs[i].be; wraddress = vecs[i].wa;
            data = vecs[i].data; rden = vecs[i].rden; rdaddress = vecs[i].ra;
            tick();
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_rv", i), {31'b0, rvalid}, {31'b0, vecs[i].exp_rv});
        end
        idle_inputs();

        // Hold: one read of addr 5, then four idle cycles.
        do_read(6'd5, 32'hAA22CC44, "hold_rd");
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("hold%0d_q", i), q, 32'hAA22CC44);
            check($sformatf("hold%0d_rv", i), {31'b0, rvalid}, 32'd0);
        end

        // Clear restart: second clr 10 cycles after the first; writes/reads ignored.
        clr = 1;
        tick();
        clr = 0;
        n = 0;
        while (busy && n < 500) begin
            n++;
            if (n == 22) check("busy_rd_ignored", {31'b0, rvalid}, 32'd0);
            idle_inputs();
            if (n == 10) begin
                clr = 1; wren = 1; wraddress = 6'd3; data = 32'hFFFFFFFF; be = 4'hF;
            end
            if (n == 21) begin
                rden = 1; rdaddress = 6'd5;
            end
            if (n == 30) begin
                wren = 1; wraddress = 6'd3; data = 32'h5555AAAA; be = 4'hF;
            end
            tick();
        end
        idle_inputs();
        check("restart_busy_cycles", n, 74);
        check("restart_q_held", q, 32'hAA22CC44);
        do_read(6'd3, 32'h0, "clr_addr3");
        do_read(6'd63, 32'h0, "clr_addr63");
        do_read(6'd5, 32'h0, "clr_addr5");

        // Reset mid-sweep at address 40.
        do_write(6'd50, 32'h12345678, 4'hF);
        do_read(6'd50, 32'h12345678, "pre_rst_rd");
        clr = 1;
        tick();
        clr = 0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check("mid_sweep_reached", n, 40);
        rst_n = 0;
        tick();
        check("mid_rst_q", q, 32'h0);
        rst_n = 1;
        n = 0;
        while (busy && n < 500) begin
            n++;
            tick();
        end
        check("mid_rst_busy_cycles", n, 64);
        do_read(6'd50, 32'h0, "post_rst_addr50");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_be_clr.md
RAM_BE_CLR -- requirements
Module: ram_be_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits; multiple of LANE_W.
REQ-002 SHALL have parameter DEPTH, default 64, number of words; power of two, >= 2.
REQ-003 SHALL have parameter LANE_W, default 8, bits per write-enable lane; NL = WIDTH/LANE_W, AW = $clog2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clr  input  1  one-cycle request to zero the whole array.
REQ-007 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-008 SHALL have port data  input  WIDTH  write data.
REQ-009 SHALL have port wraddress  input  AW  write address.
REQ-010 SHALL have port wren  input  1  write strobe.
REQ-011 SHALL have port be  input  NL  per-lane write enable; lane i covers data[i*LANE_W +: LANE_W].
REQ-012 SHALL have port rdaddress  input  AW  read address.
REQ-013 SHALL have port rden  input  1  read strobe.
REQ-014 SHALL have port q  output  WIDTH  registered read data.
REQ-015 SHALL have port rvalid  output  1  q updated this cycle.

Function
REQ-016 SHALL write only lanes with be[i]=1 when wren=1 and busy=0; other lanes keep prior contents.
REQ-017 SHALL return mem[rdaddress] on q one cycle after rden=1 with busy=0, with rvalid=1 in that same cycle.
REQ-018 SHALL hold q unchanged and drive rvalid=0 in any cycle following one where no read was accepted.
REQ-019 SHALL have two states: IDLE and CLEAR; IDLE->CLEAR on clr=1; CLEAR->IDLE after writing address DEPTH-1.
REQ-020 SHALL in CLEAR write all-zero data to one address per cycle, ascending from 0; sweep takes exactly DEPTH cycles.
REQ-021 SHALL drive busy=1 in every CLEAR cycle and busy=0 in IDLE.
REQ-022 SHALL ignore wren and rden while busy=1 (no write, rvalid=0 next cycle).
REQ-023 SHALL restart the sweep at address 0 when clr=1 arrives during CLEAR.
REQ-024 SHALL treat sweep counter wrap at DEPTH-1 as end of sweep, never as address 0 of a second pass.
REQ-025 SHALL treat be=0 with wren=1 as a no-op.

Reset
REQ-026 SHALL on rst_n=0 at a clock edge set q=0, rvalid=0, sweep address 0, state CLEAR.
REQ-027 SHALL therefore auto-clear after reset: busy=1 in the first cycle after rst_n rises, for DEPTH cycles.
REQ-028 SHALL abort any sweep in progress and restart from address 0 on reset mid-operation.
REQ-029 SHALL not reset the storage array directly; contents are defined only by the sweep.

Configuration
REQ-030 SHALL with RAM_BE_CLR_BYPASS_EN defined return newly written lanes on q when rden and wren hit the same address in the same cycle (unwritten lanes from the array).
REQ-031 SHALL without RAM_BE_CLR_BYPASS_EN return the pre-write (old) contents in that case.

Structure
REQ-032 SHALL place the state enum (IDLE, CLEAR) and default LANE_W in shared package ram_pkg.
REQ-033 SHALL implement the sweep state machine and address counter in sub-module ram_clr_ctrl; the array and read path stay in ram_be_clr.

Verification
REQ-034 SHALL check reset: rst_n low 2 cycles -> busy high 64 cycles (DEPTH=64), then reads of addresses 0, 31, 63 return 0.
REQ-035 SHALL check lanes: write 0xAABBCCDD be=4'b1111 to addr 5, then 0x11223344 be=4'b0101 -> read addr 5 returns 0xAA22CC44 with rvalid one cycle after rden.
REQ-036 SHALL check collision: addr 9 holds 0x0, same-cycle write 0xDEADBEEF be=4'hF and read addr 9 -> q=0xDEADBEEF with macro, 0x00000000 without.
REQ-037 SHALL check clear restart: clr, then clr again 10 cycles later -> busy stays high 74 cycles total; wren to addr 3 during busy leaves it 0.
REQ-038 SHALL check hold: rden=1 addr 5 then rden=0 for 4 cycles -> q stays 0xAA22CC44, rvalid 1 then 0.
REQ-039 SHALL check reset mid-sweep: rst_n low at sweep address 40 -> sweep restarts from 0, busy high another 64 cycles.
